// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM driving PC/IR/ALU/memory/register-file controls.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       fn,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic             irWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [2:0]       aluOp,
  output logic             extOp,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic [1:0]       regDst,
  output logic [1:0]       memToR,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t curState, nxtState;

  logic isAdd, isSub, isJr, isLw, isSw, isBeq, isOri, isLui, isJal, isLegal;

  assign isAdd   = (op == OP_RTYPE) && (fn == FN_ADD);
  assign isSub   = (op == OP_RTYPE) && (fn == FN_SUB);
  assign isJr    = (op == OP_RTYPE) && (fn == FN_JR);
  assign isLw    = (op == OP_LW);
  assign isSw    = (op == OP_SW);
  assign isBeq   = (op == OP_BEQ);
  assign isOri   = (op == OP_ORI);
  assign isLui   = (op == OP_LUI);
  assign isJal   = (op == OP_JAL);
  assign isLegal = isAdd | isSub | isJr | isLw | isSw | isBeq | isOri | isLui | isJal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) curState <= IDLE;
    else          curState <= nxtState;
  end

  // memReady is a completion strobe: an access in FETCH or MEM finishes in the
  // cycle memReady=1; while it is 0 the strobes stay asserted and the state holds.
  always_comb begin
    nxtState = curState;
    pcWrite  = 1'b0;
    pcSrc    = 2'd0;
    irWrite  = 1'b0;
    aluSrcA  = 1'b0;
    aluSrcB  = 2'd0;
    aluOp    = 3'b000;
    extOp    = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    regWrite = 1'b0;
    regDst   = 2'd0;
    memToR   = 2'd0;
    illegal  = 1'b0;
    case (curState)
      IDLE: nxtState = FETCH;
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'd1;
        if (memReady) begin
          irWrite  = 1'b1;
          pcWrite  = 1'b1;
          nxtState = DECODE;
        end
      end
      DECODE: begin
        aluSrcB = 2'd3;
        extOp   = 1'b1;
        if (!isLegal) begin
          illegal  = 1'b1;
          nxtState = FETCH;
        end else if (isLui || isJal) begin
          nxtState = WB;
        end else begin
          nxtState = EXEC;
        end
      end
      EXEC: begin
        nxtState = FETCH;
        if (isAdd || isSub) begin
          aluSrcA  = 1'b1;
          aluOp    = isSub ? 3'b001 : 3'b000;
          nxtState = WB;
        end else if (isLw || isSw) begin
          aluSrcA  = 1'b1;
          aluSrcB  = 2'd2;
          extOp    = 1'b1;
          nxtState = MEM;
        end else if (isOri) begin
          aluSrcA  = 1'b1;
          aluSrcB  = 2'd2;
          aluOp    = 3'b011;
          nxtState = WB;
        end else if (isBeq) begin
          aluSrcA = 1'b1;
          aluOp   = 3'b100;
          pcWrite = zero;
          pcSrc   = 2'd1;
        end else if (isJr) begin
          pcWrite = 1'b1;
          pcSrc   = 2'd2;
        end
      end
      MEM: begin
        if (isLw) begin
          memRead = 1'b1;
          if (memReady) nxtState = WB;
        end else begin
          memWrite = 1'b1;
          if (memReady) nxtState = FETCH;
        end
      end
      WB: begin
        regWrite = 1'b1;
        nxtState = FETCH;
        if (isAdd || isSub) begin
          regDst = 2'b01;
        end else if (isLw) begin
          memToR = 2'b01;
        end else if (isLui) begin
          memToR = 2'b10;
        end else if (isJal) begin
          // $31 takes the PC that FETCH already advanced by 4.
          regDst  = 2'b10;
          memToR  = 2'b11;
          pcWrite = 1'b1;
          pcSrc   = 2'd3;
        end
      end
      default: nxtState = IDLE;
    endcase
  end

  assign state = curState;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] retiredQ, cyclesQ;
  logic retire;

  assign retire = (nxtState == FETCH) &&
                  ((curState == EXEC) || (curState == MEM) || (curState == WB) ||
                   ((curState == DECODE) && !illegal));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retiredQ <= '0;
      cyclesQ  <= '0;
    end else begin
      if (curState != IDLE) cyclesQ <= cyclesQ + CNT_W'(1);
      if (retire)           retiredQ <= retiredQ + CNT_W'(1);
    end
  end

  assign retired = retiredQ;
  assign cycles  = cyclesQ;
`else
  assign retired = '0;
  assign cycles  = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: reset checks, a latency/result vector table, reset
// during a store, counter checks, and random instructions against a trace model.
module tb_mc_controller;

  localparam int W = 22;
  localparam int K_ADD = 0, K_SUB = 1, K_JR = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_ORI = 6, K_LUI = 7, K_JAL = 8, K_ILL = 9;

  typedef struct packed {
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       irWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       extOp;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToR;
    logic       illegal;
    logic [2:0] state;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    int         memStall;
    int         expLen;
    logic [9:0] expLast;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] fn = '0;
  logic zero = 1'b0;
  logic memReady = 1'b0;
  logic pcWrite, irWrite, aluSrcA, extOp, memRead, memWrite, regWrite, illegal;
  logic [1:0] pcSrc, aluSrcB, regDst, memToR;
  logic [2:0] aluOp, state;
  logic [31:0] retired, cycles;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .fn(fn), .zero(zero), .memReady(memReady),
    .pcWrite(pcWrite), .pcSrc(pcSrc), .irWrite(irWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .extOp(extOp), .memRead(memRead),
    .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst), .memToR(memToR),
    .illegal(illegal), .state(state), .retired(retired), .cycles(cycles)
  );

  ctl_t act;
  assign act = {pcWrite, pcSrc, irWrite, aluSrcA, aluSrcB, aluOp, extOp, memRead,
                memWrite, regWrite, regDst, memToR, illegal, state};

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  logic [W-1:0] exp_q[$];
  logic rdyQ[$];
  logic zeroQ[$];
  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    nCmp++;
    if (a !== e) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [9:0] pick(input ctl_t c);
    return {c.pcWrite, c.pcSrc, c.memWrite, c.regWrite, c.regDst, c.memToR, c.illegal};
  endfunction

  task automatic push(input ctl_t c, input logic r, input logic z);
    exp_q.push_back(c);
    rdyQ.push_back(r);
    zeroQ.push_back(z);
  endtask

  // Expected per-cycle controls for one instruction, from the phase rules.
  task automatic buildTrace(input int k, input int fs, input int ms);
    ctl_t c;
    logic z;
    for (int i = 0; i < fs; i++) begin
      c = '0; c.state = 3'd1; c.memRead = 1'b1; c.aluSrcB = 2'd1;
      push(c, 1'b0, rnd());
    end
    c = '0; c.state = 3'd1; c.memRead = 1'b1; c.aluSrcB = 2'd1;
    c.irWrite = 1'b1; c.pcWrite = 1'b1;
    push(c, 1'b1, rnd());
    c = '0; c.state = 3'd2; c.aluSrcB = 2'd3; c.extOp = 1'b1; c.illegal = (k == K_ILL);
    push(c, rnd(), rnd());
    if (k == K_ILL) return;
    if (k != K_LUI && k != K_JAL) begin
      c = '0; c.state = 3'd3; z = rnd();
      case (k)
        K_ADD: c.aluSrcA = 1'b1;
        K_SUB: begin c.aluSrcA = 1'b1; c.aluOp = 3'b001; end
        K_LW, K_SW: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.extOp = 1'b1; end
        K_ORI: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluOp = 3'b011; end
        K_BEQ: begin c.aluSrcA = 1'b1; c.aluOp = 3'b100; c.pcWrite = z; c.pcSrc = 2'd1; end
        K_JR:  begin c.pcWrite = 1'b1; c.pcSrc = 2'd2; end
        default: ;
      endcase
      push(c, rnd(), z);
      if (k == K_BEQ || k == K_JR) return;
    end
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= ms; i++) begin
        c = '0; c.state = 3'd4; c.memRead = (k == K_LW); c.memWrite = (k == K_SW);
        push(c, (i == ms), rnd());
      end
      if (k == K_SW) return;
    end
    c = '0; c.state = 3'd5; c.regWrite = 1'b1;
    case (k)
      K_ADD, K_SUB: c.regDst = 2'b01;
      K_LW:  c.memToR = 2'b01;
      K_LUI: c.memToR = 2'b10;
      K_JAL: begin c.regDst = 2'b10; c.memToR = 2'b11; c.pcWrite = 1'b1; c.pcSrc = 2'd3; end
      default: ;
    endcase
    push(c, rnd(), rnd());
  endtask

  task automatic encode(input int k, output logic [5:0] o, output logic [5:0] f);
    logic [5:0] t;
    f = 6'($urandom_range(0, 63));
    case (k)
      K_ADD: begin o = 6'b000000; f = 6'b100000; end
      K_SUB: begin o = 6'b000000; f = 6'b100010; end
      K_JR:  begin o = 6'b000000; f = 6'b001000; end
      K_LW:  o = 6'b100011;
      K_SW:  o = 6'b101011;
      K_BEQ: o = 6'b000100;
      K_ORI: o = 6'b001101;
      K_LUI: o = 6'b001111;
      K_JAL: o = 6'b000011;
      default: begin
        if (rnd()) begin
          o = 6'b000000;
          while (f == 6'b100000 || f == 6'b100010 || f == 6'b001000) f = 6'($urandom_range(0, 63));
        end else begin
          t = 6'($urandom_range(0, 63));
          while (t == 6'b000000 || t == 6'b100011 || t == 6'b101011 || t == 6'b000100 ||
                 t == 6'b001101 || t == 6'b001111 || t == 6'b000011) t = 6'($urandom_range(0, 63));
          o = t;
        end
      end
    endcase
  endtask

  // Starts and ends in FETCH; measures cycles until the next FETCH.
  task automatic runVec(input int idx, input vec_t v);
    int len;
    int memLow;
    logic [9:0] last;
    op = v.op; fn = v.fn; zero = v.zero;
    len = 0; memLow = v.memStall; last = '0;
    do begin
      memReady = 1'b1;
      if (state == 3'd4 && memLow > 0) begin
        memReady = 1'b0;
        memLow--;
      end
      #1;
      last = pick(act);
      tick();
      len++;
    end while (state != 3'd1 && len < 20);
    check($sformatf("vec%0d_len", idx), 32'(len), 32'(v.expLen));
    check($sformatf("vec%0d_last", idx), 32'(last), 32'(v.expLast));
  endtask

  initial begin
    #1000000;
    nBad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    int expR, expC, k, fs, ms, len;
    logic [5:0] o, f;
    logic r, z;
    logic [W-1:0] e;

    vt[0]  = '{6'b000000, 6'b100000, 1'b0, 0, 4, 10'b0_00_0_1_01_00_0};
    vt[1]  = '{6'b000000, 6'b100010, 1'b1, 0, 4, 10'b0_00_0_1_01_00_0};
    vt[2]  = '{6'b000000, 6'b001000, 1'b0, 0, 3, 10'b1_10_0_0_00_00_0};
    vt[3]  = '{6'b100011, 6'b000000, 1'b0, 2, 7, 10'b0_00_0_1_00_01_0};
    vt[4]  = '{6'b101011, 6'b000000, 1'b0, 0, 4, 10'b0_00_1_0_00_00_0};
    vt[5]  = '{6'b101011, 6'b000000, 1'b0, 1, 5, 10'b0_00_1_0_00_00_0};
    vt[6]  = '{6'b000100, 6'b000000, 1'b1, 0, 3, 10'b1_01_0_0_00_00_0};
    vt[7]  = '{6'b000100, 6'b000000, 1'b0, 0, 3, 10'b0_01_0_0_00_00_0};
    vt[8]  = '{6'b001101, 6'b000000, 1'b0, 0, 4, 10'b0_00_0_1_00_00_0};
    vt[9]  = '{6'b001111, 6'b000000, 1'b0, 0, 3, 10'b0_00_0_1_00_10_0};
    vt[10] = '{6'b000011, 6'b000000, 1'b0, 0, 3, 10'b1_11_0_1_10_11_0};
    vt[11] = '{6'b111111, 6'b000000, 1'b0, 0, 2, 10'b0_00_0_0_00_00_1};
    vt[12] = '{6'b000000, 6'b000000, 1'b0, 0, 2, 10'b0_00_0_0_00_00_1};

    // Reset and first fetch.
    reset_n = 1'b0; memReady = 1'b1; op = 6'b001111; fn = '0;
    #12;
    check("rst_ctl", 32'(act), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_cycles", cycles, 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("idle_ctl", 32'(act), 32'd0);
    tick();
    check("fetch_state", 32'(state), 32'd1);
    check("fetch_ir_pc", 32'({irWrite, pcWrite}), 32'b11);
    tick();
    check("decode_state", 32'(state), 32'd2);
    tick();
    tick();
    check("back_fetch", 32'(state), 32'd1);

    for (int i = 0; i < 13; i++) runVec(i, vt[i]);

    // Reset during the MEM phase of a store.
    op = 6'b101011; memReady = 1'b1;
    tick(); tick(); tick();
    memReady = 1'b0;
    #1;
    check("sw_mem_write", 32'({state, memWrite}), 32'({3'd4, 1'b1}));
    reset_n = 1'b0;
    #1;
    check("sw_rst_ctl", 32'(act), 32'd0);
    memReady = 1'b1;
    tick();
    check("sw_rst_hold", 32'(act), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_fetch", 32'(state), 32'd1);
    check("post_rst_retired", retired, 32'd0);
    check("post_rst_cycles", cycles, 32'd0);

    // Three lui instructions, three cycles each.
    op = 6'b001111;
    repeat (9) tick();
    check("lui3_state", 32'(state), 32'd1);
`ifdef MC_PERF_CNT_EN
    expR = 3; expC = 9;
`else
    expR = 0; expC = 0;
`endif
    check("lui3_retired", retired, 32'(expR));
    check("lui3_cycles", cycles, 32'(expC));

    // Random instruction mix with random memory stalls.
    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 9);
      fs = $urandom_range(0, 3);
      ms = $urandom_range(0, 3);
      encode(k, o, f);
      buildTrace(k, fs, ms);
      len = exp_q.size();
      op = o; fn = f;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        r = rdyQ.pop_front();
        z = zeroQ.pop_front();
        memReady = r; zero = z;
        #1;
        check($sformatf("rand%0d_op%0h_fn%0h", n, o, f), 32'(act), 32'(e));
        tick();
      end
`ifdef MC_PERF_CNT_EN
      expC += len;
      if (k != K_ILL) expR++;
`endif
    end
    #1;
    check("rand_end_state", 32'(state), 32'd1);
    check("rand_retired", retired, 32'(expR));
    check("rand_cycles", cycles, 32'(expC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
